// File: rtl/gpc_pkg.sv
// Shared constants for the gpc3111_5 compressor and its round-robin accumulator wrapper.
package gpc_pkg;

    // Compressor operand and count widths
    localparam int unsigned GPC3111_IN_W  = 6;
    localparam int unsigned GPC3111_OUT_W = 5;

    // Bit positions inside the packed operand {src3[2:0], src2[0], src1[0], src0[0]}
    localparam int unsigned SRC0_BIT = 0;
    localparam int unsigned SRC1_BIT = 1;
    localparam int unsigned SRC2_BIT = 2;
    localparam int unsigned SRC3_LSB = 3;

    // Column weights of the four compressor inputs
    localparam int unsigned W_SRC0 = 1;
    localparam int unsigned W_SRC1 = 2;
    localparam int unsigned W_SRC2 = 4;
    localparam int unsigned W_SRC3 = 8;

    // Index width for n entries, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpc3111_5.sv
// gpc3111_5 generalized parallel counter: weighted count of a 6-bit operand (range 0..31).
module gpc3111_5
    import gpc_pkg::*;
(
    input  logic [GPC3111_IN_W-1:0]  src,
    output logic [GPC3111_OUT_W-1:0] cnt
);

    // Weighted sum of the single-bit columns plus the three-bit weight-8 column
    always_comb begin
        cnt = GPC3111_OUT_W'(
                  W_SRC0 * 32'(src[SRC0_BIT])
                + W_SRC1 * 32'(src[SRC1_BIT])
                + W_SRC2 * 32'(src[SRC2_BIT])
                + W_SRC3 * (32'(src[SRC3_LSB]) + 32'(src[SRC3_LSB+1]) + 32'(src[SRC3_LSB+2])));
    end

endmodule

// File: rtl/gpc_rr_arb.sv
// Pointer-masked round-robin priority select: first eligible index at or after rr_ptr, wrapping.
module gpc_rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant_c,
    output logic [IDW-1:0]  gidx_c,
    output logic            hit_c
);

    logic [NREQ-1:0] masked;
    logic            found;

    // Search the upper (masked) half first, fall back to the full vector to wrap
    always_comb begin
        masked  = '0;
        grant_c = '0;
        gidx_c  = '0;
        found   = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            masked[i] = eligible[i] && (IDW'(i) >= rr_ptr);
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && masked[i]) begin
                found      = 1'b1;
                grant_c[i] = 1'b1;
                gidx_c     = IDW'(i);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && eligible[i]) begin
                found      = 1'b1;
                grant_c[i] = 1'b1;
                gidx_c     = IDW'(i);
            end
        end
        hit_c = found;
    end

endmodule

// File: rtl/gpc3111_rr_accum.sv
// Round-robin time-sharing of one gpc3111_5 across NREQ framed operand streams,
// accumulating per-requester frame totals and emitting them on a valid/ready port.
module gpc3111_rr_accum
    import gpc_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned ACC_W = 12,
    localparam int unsigned IDW   = clog2_min1(NREQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*GPC3111_IN_W-1:0]   req_src,
    input  logic [NREQ-1:0]                req_last,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [IDW-1:0]                 res_id,
    output logic [ACC_W-1:0]               res_sum,
    output logic                           res_ovf
);

    logic [IDW-1:0]           rr_ptr;
    logic [ACC_W-1:0]         acc [NREQ];
    logic [NREQ-1:0]          ovf;

    logic                     out_free;
    logic [NREQ-1:0]          eligible;
    logic [NREQ-1:0]          grant;
    logic [IDW-1:0]           gidx;
    logic                     hit;

    logic [GPC3111_IN_W-1:0]  src_sel;
    logic [ACC_W-1:0]         acc_sel;
    logic                     ovf_sel;
    logic                     last_sel;
    logic [GPC3111_OUT_W-1:0] cnt;
    logic [ACC_W:0]           sum;
    logic                     carry;
    logic                     hs;
    logic                     hs_last;

    // Last beats wait for a free result slot; non-last beats never stall
    always_comb begin
        out_free = !res_valid || res_ready;
        eligible = req_valid & (~req_last | {NREQ{out_free}});
    end

    gpc_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .grant_c  (grant),
        .gidx_c   (gidx),
        .hit_c    (hit)
    );

    // Ready is the grant itself, forced low while reset is held
    always_comb begin
        req_ready = grant & {NREQ{rst_n}};
    end

    // One-hot mux of the granted requester's operand, accumulator and flags
    always_comb begin
        src_sel  = '0;
        acc_sel  = '0;
        ovf_sel  = 1'b0;
        last_sel = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                src_sel  = req_src[i*GPC3111_IN_W +: GPC3111_IN_W];
                acc_sel  = acc[i];
                ovf_sel  = ovf[i];
                last_sel = req_last[i];
            end
        end
    end

    gpc3111_5 u_gpc (
        .src (src_sel),
        .cnt (cnt)
    );

    // Accumulate at one extra bit so the carry out flags frame overflow
    always_comb begin
        sum     = {1'b0, acc_sel} + (ACC_W+1)'(cnt);
        carry   = sum[ACC_W];
        hs      = hit;
        hs_last = hit && last_sel;
    end

    // Round-robin pointer moves just past the winner on every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
        end
    end

    // Per-requester accumulators; cleared when the frame closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                acc[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (hs && grant[i]) begin
                    if (last_sel) begin
                        acc[i] <= '0;
                        ovf[i] <= 1'b0;
                    end else begin
                        acc[i] <= sum[ACC_W-1:0];
                        ovf[i] <= ovf[i] | carry;
                    end
                end
            end
        end
    end

    // Result register: loads on a last beat, otherwise drains on consumer accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_sum   <= '0;
            res_ovf   <= 1'b0;
        end else if (hs_last) begin
            res_valid <= 1'b1;
            res_id    <= gidx;
            res_sum   <= sum[ACC_W-1:0];
            res_ovf   <= ovf_sel | carry;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
